rom_download_sequencer: RTL and testbench

//  Sequences the HPS ioctl download stream into the Traverse USA / Shot Rider core.

---
 rtl/rom_download_sequencer.sv | 151 +++++++++++++++
 tb/tb_rom_download_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_sequencer.sv
// Routes the HPS ioctl download stream to the ROM loader, game-select and DIP bank,
// paces ROM writes and holds the core in reset around a download.
module rom_download_sequencer #(
    parameter int unsigned ROM_SIZE    = 'h1_C000,
    parameter int unsigned WR_GAP      = 4,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        reset_req,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [63:0] dip_sw,
    output logic        mod_traverseusa,
    output logic        mod_shotrider,
    output logic        core_reset,
    output logic        rom_ovf
);

    localparam int unsigned GAP_W  = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(WR_GAP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [24:0]       ROM_LIMIT = 25'(ROM_SIZE);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_cnt;
    logic              pend_valid;
    logic [16:0]       pend_addr;
    logic [7:0]        pend_data;

    logic wr_rom, wr_mod, wr_dip, rom_in_range;
    assign wr_rom       = ioctl_wr && (ioctl_index == 8'd0);
    assign wr_mod       = ioctl_wr && (ioctl_index == 8'd1);
    assign wr_dip       = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0);
    assign rom_in_range = ioctl_addr < ROM_LIMIT;

    // The HPS stall flag is exactly the pending-buffer occupancy
    assign ioctl_wait = pend_valid;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE:  if (ioctl_download) state_d = LOAD;
            LOAD:  if (!ioctl_download) state_d = DRAIN;
            DRAIN: begin
                if (ioctl_download) begin
                    state_d = LOAD;
                end else if (!pend_valid) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (ioctl_download)        state_d = LOAD;
                else if (hold_q == '0)     state_d = IDLE;
                else                       hold_d  = hold_q - HOLD_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            core_reset <= 1'b1;
        end else begin
            core_reset <= reset_req || (state_d != IDLE);
        end
    end

    // Game-select and DIP bank are plain register writes, independent of pacing
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dip_sw          <= '0;
            mod_traverseusa <= 1'b1;
            mod_shotrider   <= 1'b0;
        end else begin
            if (wr_mod) begin
                mod_traverseusa <= (ioctl_dout == 8'd0);
                mod_shotrider   <= (ioctl_dout == 8'd1);
            end
            if (wr_dip) dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

    // ROM write pacing with a single-entry overflow buffer
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            gap_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            rom_ovf    <= 1'b0;
        end else begin
            dn_wr <= 1'b0;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
            if (state_q == IDLE && state_d == LOAD) rom_ovf <= 1'b0;

            if (pend_valid && gap_cnt == '0) begin
                dn_wr      <= 1'b1;
                dn_addr    <= pend_addr;
                dn_data    <= pend_data;
                gap_cnt    <= GAP_LOAD;
                pend_valid <= 1'b0;
            end

            if (wr_rom) begin
                if (!rom_in_range || pend_valid) begin
                    rom_ovf <= 1'b1;
                end else if (gap_cnt == '0) begin
                    dn_wr   <= 1'b1;
                    dn_addr <= ioctl_addr[16:0];
                    dn_data <= ioctl_dout;
                    gap_cnt <= GAP_LOAD;
                end else begin
                    pend_valid <= 1'b1;
                    pend_addr  <= ioctl_addr[16:0];
                    pend_data  <= ioctl_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_download_sequencer.sv
// Self-checking bench for rom_download_sequencer: ROM pacing scoreboard, DIP/mod
// registers, reset hold tail, overflow flag and mid-download reset recovery.
module tb_rom_download_sequencer;

    localparam int unsigned WR_GAP      = 4;
    localparam int unsigned HOLD_CYCLES = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        reset_req;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [63:0] dip_sw;
    logic        mod_traverseusa;
    logic        mod_shotrider;
    logic        core_reset;
    logic        rom_ovf;

    rom_download_sequencer #(
        .ROM_SIZE   ('h1_C000),
        .WR_GAP     (WR_GAP),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .reset_req      (reset_req),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .dip_sw         (dip_sw),
        .mod_traverseusa(mod_traverseusa),
        .mod_shotrider  (mod_shotrider),
        .core_reset     (core_reset),
        .rom_ovf        (rom_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: expected {addr,data} pushed at stimulus, observed pulses captured here
    logic [24:0] exp_q[$];
    logic [24:0] obs_q[$];
    int unsigned obs_cyc[$];
    int unsigned cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (dn_wr === 1'b1) begin
            obs_q.push_back({dn_addr, dn_data});
            obs_cyc.push_back(cyc);
        end
    end

    // HPS-side write: honours ioctl_wait, one-cycle strobe, returns on the following negedge
    task automatic hps_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait === 1'b1 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hps_wait_timeout: ioctl_wait still %b after %0d cycles, required 0", ioctl_wait, n);
        end
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        @(negedge clk_sys);
        ioctl_wr    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        reset_req      = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        repeat (3) @(negedge clk_sys);
        n_cmp++;
        if ({core_reset, dn_wr, ioctl_wait, rom_ovf} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags: got {core_reset,dn_wr,wait,ovf}=%b, required 1000",
                     {core_reset, dn_wr, ioctl_wait, rom_ovf});
        end
        n_cmp++;
        if ({dn_addr, dn_data} !== 25'd0 || dip_sw !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h data=%h dip=%h, required all 0", dn_addr, dn_data, dip_sw);
        end
        n_cmp++;
        if ({mod_traverseusa, mod_shotrider} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_mod: got %b, required 10", {mod_traverseusa, mod_shotrider});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        n_cmp++;
        if (core_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: core_reset=%b, required 0", core_reset);
        end
    endtask

    task automatic test_rom_stream();
        logic [24:0] o;
        logic [24:0] e;
        int unsigned prev_c = 0;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({17'(i), 8'hA0 + 8'(i)});
            hps_write(8'd0, 25'(i), 8'hA0 + 8'(i));
            // first byte issues directly, the rest land in the buffer behind the gap
            n_cmp++;
            if (ioctl_wait !== (i != 0)) begin
                n_bad++;
                $display("FAIL stream_wait[%0d]: ioctl_wait=%b, required %b", i, ioctl_wait, (i != 0));
            end
            @(negedge clk_sys);
        end
        repeat (8) @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL stream_data[%0d]: no dn_wr seen, required %h", i, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL stream_data[%0d]: got %h, required %h", i, o, e);
                end
                if (i != 0) begin
                    n_cmp++;
                    if (obs_cyc[0] - prev_c != WR_GAP) begin
                        n_bad++;
                        $display("FAIL stream_gap[%0d]: spacing %0d, required %0d", i, obs_cyc[0] - prev_c, WR_GAP);
                    end
                end
                prev_c = obs_cyc.pop_front();
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL stream_extra: %0d unexpected dn_wr pulses, required 0", obs_q.size());
            obs_q.delete();
            obs_cyc.delete();
        end
    endtask

    task automatic test_dip();
        logic [63:0] exp_dip = 64'd0;
        hps_write(8'd254, 25'd2, 8'h5C);
        exp_dip[23:16] = 8'h5C;
        n_cmp++;
        if (dip_sw !== exp_dip) begin
            n_bad++;
            $display("FAIL dip_byte2: got %h, required %h", dip_sw, exp_dip);
        end
        hps_write(8'd254, 25'd8, 8'hFF);
        n_cmp++;
        if (dip_sw !== exp_dip) begin
            n_bad++;
            $display("FAIL dip_addr8: got %h, required %h", dip_sw, exp_dip);
        end
        hps_write(8'd254, 25'd7, 8'h11);
        exp_dip[63:56] = 8'h11;
        n_cmp++;
        if (dip_sw !== exp_dip) begin
            n_bad++;
            $display("FAIL dip_byte7: got %h, required %h", dip_sw, exp_dip);
        end
    endtask

    task automatic test_mod();
        logic [7:0] vals [3] = '{8'h01, 8'h02, 8'h00};
        logic [1:0] want [3] = '{2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 3; i++) begin
            hps_write(8'd1, 25'h55, vals[i]);
            n_cmp++;
            if ({mod_traverseusa, mod_shotrider} !== want[i]) begin
                n_bad++;
                $display("FAIL mod[%0d]: got {tu,sr}=%b, required %b", i, {mod_traverseusa, mod_shotrider}, want[i]);
            end
        end
    endtask

    // Counts sampled cycles with core_reset high after download falls: one DRAIN cycle plus the tail
    task automatic count_hold(output int n);
        n = 0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        while (core_reset === 1'b1 && n < 200) begin
            n++;
            @(negedge clk_sys);
        end
    endtask

    task automatic test_hold();
        int n;
        count_hold(n);
        n_cmp++;
        if (n != HOLD_CYCLES + 1) begin
            n_bad++;
            $display("FAIL hold_len: core_reset high %0d cycles, required %0d", n, HOLD_CYCLES + 1);
        end
        reset_req = 1'b1;
        @(negedge clk_sys);
        n_cmp++;
        if (core_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_req_on: core_reset=%b, required 1", core_reset);
        end
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (HOLD_CYCLES + 6) @(negedge clk_sys);
        n_cmp++;
        if (core_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_req_held: core_reset=%b, required 1", core_reset);
        end
        reset_req = 1'b0;
        @(negedge clk_sys);
        n_cmp++;
        if (core_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_req_off: core_reset=%b, required 0", core_reset);
        end
    endtask

    task automatic test_overflow();
        logic [24:0] o;
        logic [24:0] e;
        int n;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        exp_q.push_back({17'h1BFFF, 8'h3C});
        hps_write(8'd0, 25'h1BFFF, 8'h3C);
        repeat (6) @(negedge clk_sys);
        e = exp_q.pop_front();
        o = (obs_q.size() != 0) ? obs_q.pop_front() : 25'h1FFFFFF;
        if (obs_cyc.size() != 0) void'(obs_cyc.pop_front());
        n_cmp++;
        if (o !== e || rom_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_last_addr: got wr=%h ovf=%b, required wr=%h ovf=0", o, rom_ovf, e);
        end
        hps_write(8'd0, 25'h1C000, 8'h77);
        repeat (6) @(negedge clk_sys);
        n_cmp++;
        if (obs_q.size() != 0 || rom_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_drop: got %0d pulses ovf=%b, required 0 pulses ovf=1", obs_q.size(), rom_ovf);
            obs_q.delete();
            obs_cyc.delete();
        end
        count_hold(n);
        n_cmp++;
        if (rom_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky: rom_ovf=%b after download, required 1", rom_ovf);
        end
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        n_cmp++;
        if (rom_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: rom_ovf=%b on new download, required 0", rom_ovf);
        end
    endtask

    task automatic test_reset_mid_download();
        logic [24:0] o;
        logic [24:0] e;
        int n;
        repeat (4) @(negedge clk_sys);
        exp_q.push_back({17'd5, 8'h11});
        hps_write(8'd0, 25'd5, 8'h11);
        hps_write(8'd0, 25'd6, 8'h22);
        n_cmp++;
        if (ioctl_wait !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pending: ioctl_wait=%b, required 1", ioctl_wait);
        end
        reset_n = 1'b0;
        @(negedge clk_sys);
        n_cmp++;
        if (ioctl_wait !== 1'b0 || core_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_flags: wait=%b core_reset=%b, required 0/1", ioctl_wait, core_reset);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (8) @(negedge clk_sys);
        n_cmp++;
        if (core_reset !== 1'b1 || dip_sw !== 64'd0) begin
            n_bad++;
            $display("FAIL midrst_recover: core_reset=%b dip=%h, required 1/0", core_reset, dip_sw);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== e) begin
            n_bad++;
            $display("FAIL midrst_writes: got %0d pulses first=%h, required 1 pulse %h",
                     obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 25'h0, e);
        end
        obs_q.delete();
        obs_cyc.delete();
        count_hold(n);
        n_cmp++;
        if (n != HOLD_CYCLES + 1) begin
            n_bad++;
            $display("FAIL midrst_load: hold after recovery %0d cycles, required %0d", n, HOLD_CYCLES + 1);
        end
    endtask

    initial begin
        test_reset();
        test_rom_stream();
        test_dip();
        test_mod();
        test_hold();
        test_overflow();
        test_reset_mid_download();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
